// File: rtl/uart_mem_if.sv
// Request/response bundle between host logic and uart_memory_master.
// master = host side, slave = the serialising engine.
interface uart_mem_if;
   logic       req_valid;
   logic       req_write;
   logic [7:0] req_addr;
   logic [7:0] req_data;
   logic       req_ready;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       resp_timeout;

   modport master (
      output req_valid, req_write, req_addr, req_data,
      input  req_ready, resp_valid, resp_data, resp_timeout
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      output req_ready, resp_valid, resp_data, resp_timeout
   );
endinterface

// File: rtl/uart_memory_master.sv
// Byte-serial memory protocol initiator (READ 01,addr / WRITE 02,addr,data).
// Optional read-reply timeout enabled by defining UART_MEM_TIMEOUT_EN.
module uart_memory_master
`ifdef UART_MEM_TIMEOUT_EN
#(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   uart_mem_if.slave  host,
   output logic       transmit,
   output logic [7:0] tx_byte,
   input  logic       tx_busy,
   input  logic       received,
   input  logic [7:0] rx_byte
);

   typedef enum logic [2:0] {
      IDLE, SEND_CMD, WAIT_CMD, SEND_ADDR,
      WAIT_ADDR, SEND_DATA, WAIT_DATA, WAIT_RESP
   } state_t;

   state_t     state_q, state_d;
   logic       wr_q, wr_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       got_q, got_d;
   logic [7:0] hold_q, hold_d;
   logic       ready_q, ready_d;
   logic       xmit_d;
   logic [7:0] txb_d;
   logic       rv_q, rv_d;
   logic [7:0] rd_q, rd_d;
   logic       tx_idle;

   // transmit is high exactly on the first WAIT_x cycle, masking tx latency
   assign tx_idle = !transmit && !tx_busy;

   assign host.req_ready  = ready_q;
   assign host.resp_valid = rv_q;
   assign host.resp_data  = rd_q;

`ifdef UART_MEM_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        to_q, to_d;

   assign host.resp_timeout = to_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end
`else
   assign host.resp_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         got_q    <= 1'b0;
         hold_q   <= '0;
         ready_q  <= 1'b1;
         transmit <= 1'b0;
         tx_byte  <= '0;
         rv_q     <= 1'b0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         got_q    <= got_d;
         hold_q   <= hold_d;
         ready_q  <= ready_d;
         transmit <= xmit_d;
         tx_byte  <= txb_d;
         rv_q     <= rv_d;
         rd_q     <= rd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      got_d   = got_q;
      hold_d  = hold_q;
      ready_d = ready_q;
      xmit_d  = 1'b0;
      txb_d   = tx_byte;
      rv_d    = 1'b0;
      rd_d    = rd_q;
`ifdef UART_MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (host.req_valid) begin
               wr_d    = host.req_write;
               addr_d  = host.req_addr;
               data_d  = host.req_data;
               got_d   = 1'b0;
               ready_d = 1'b0;
               state_d = SEND_CMD;
            end
         end
         SEND_CMD: begin
            if (!tx_busy) begin
               xmit_d  = 1'b1;
               txb_d   = wr_q ? 8'h02 : 8'h01;
               state_d = WAIT_CMD;
            end
         end
         WAIT_CMD: begin
            if (tx_idle) state_d = SEND_ADDR;
         end
         SEND_ADDR: begin
            if (!tx_busy) begin
               xmit_d  = 1'b1;
               txb_d   = addr_q;
               state_d = WAIT_ADDR;
`ifdef UART_MEM_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT_ADDR: begin
            // an early reply is parked until the addr byte has gone out
            if (!wr_q && received && !got_q) begin
               got_d  = 1'b1;
               hold_d = rx_byte;
            end
            if (tx_idle) begin
               if (wr_q) begin
                  state_d = SEND_DATA;
               end else if (got_q || received) begin
                  rv_d    = 1'b1;
                  rd_d    = got_q ? hold_q : rx_byte;
                  ready_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_RESP;
               end
            end
         end
         SEND_DATA: begin
            if (!tx_busy) begin
               xmit_d  = 1'b1;
               txb_d   = data_q;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (tx_idle) begin
               rv_d    = 1'b1;
               rd_d    = '0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_RESP: begin
            if (received) begin
               rv_d    = 1'b1;
               rd_d    = rx_byte;
               ready_d = 1'b1;
               state_d = IDLE;
            end
`ifdef UART_MEM_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
               to_d    = 1'b1;
               rd_d    = '0;
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_memory_master.sv
// Randomised bench for uart_memory_master with a UART tx/rx and
// remote-memory responder model; default build or UART_MEM_TIMEOUT_EN.
module tb_uart_memory_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       transmit;
   logic [7:0] tx_byte;
   logic       tx_busy = 1'b0;
   logic       received = 1'b0;
   logic [7:0] rx_byte = 8'h00;

   uart_mem_if bus ();

`ifdef UART_MEM_TIMEOUT_EN
   uart_memory_master #(.TIMEOUT_CYCLES(16'd100)) dut (
`else
   uart_memory_master dut (
`endif
      .clk      (clk),
      .rst_n    (rst_n),
      .host     (bus),
      .transmit (transmit),
      .tx_byte  (tx_byte),
      .tx_busy  (tx_busy),
      .received (received),
      .rx_byte  (rx_byte)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] sent[$], exp_tx[$], resps[$], exp_rsp[$];
   logic [7:0] frame[$];
   logic [7:0] rmem[256];
   logic [7:0] ref_mem[256];
   int         cyc = 0, busy = 0, touts = 0;
   bit         rsp_en = 1, dbl = 0, pend = 0, pend2 = 0;
   int         rsp_delay = 20, rx_at = 0, rx_at2 = 0;
   logic [7:0] rx_val = 0, stray_val = 0;
   int         stray_req = 0, stray_done = 0;

   // UART tx/rx plus remote memory responder, all on the falling edge
   always @(negedge clk) begin
      cyc++;
      received = 1'b0;
      if (!rst_n) begin
         busy = 0;
         frame.delete();
         pend = 0;
         pend2 = 0;
      end else begin
         if (transmit) begin
            sent.push_back(tx_byte);
            frame.push_back(tx_byte);
            busy = 10;
            if (frame[0] == 8'h02 && frame.size() == 3) begin
               rmem[frame[1]] = frame[2];
               frame.delete();
            end else if (frame[0] == 8'h01 && frame.size() == 2) begin
               rx_val = rmem[frame[1]];
               if (rsp_en) begin
                  pend = 1;
                  rx_at = cyc + rsp_delay;
                  pend2 = dbl;
                  rx_at2 = rx_at + 2;
               end
               frame.delete();
            end else if (frame[0] != 8'h01 && frame[0] != 8'h02) begin
               frame.delete();
            end
         end else if (busy > 0) begin
            busy--;
         end
         if (pend && cyc == rx_at) begin
            received = 1'b1;
            rx_byte = rx_val;
            pend = 0;
         end else if (pend2 && cyc == rx_at2) begin
            received = 1'b1;
            rx_byte = ~rx_val;
            pend2 = 0;
         end else if (stray_req != stray_done) begin
            received = 1'b1;
            rx_byte = stray_val;
            stray_done++;
         end
      end
      tx_busy = (busy > 0);
      if (bus.resp_valid) begin
         resps.push_back(bus.resp_data);
         chk("ready_on_resp", bus.req_ready, 1);
      end
      if (bus.resp_timeout) begin
         touts++;
         chk("valid_and_timeout", bus.resp_valid, 0);
      end
   end

   task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d);
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_data  = d;
      if (w) begin
         exp_tx.push_back(8'h02);
         exp_tx.push_back(a);
         exp_tx.push_back(d);
         ref_mem[a] = d;
         exp_rsp.push_back(8'h00);
      end else begin
         exp_tx.push_back(8'h01);
         exp_tx.push_back(a);
         exp_rsp.push_back(ref_mem[a]);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int n);
      int k = 0;
      while (resps.size() < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("resp_count", resps.size(), n);
   endtask

   task automatic wait_sent(input int n);
      int k = 0;
      while (sent.size() < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("sent_count", sent.size(), n);
   endtask

   task automatic compare(input string tag);
      chk({tag, "_ntx"}, sent.size(), exp_tx.size());
      while (sent.size() > 0 && exp_tx.size() > 0)
         chk({tag, "_tx"}, sent.pop_front(), exp_tx.pop_front());
      chk({tag, "_nrsp"}, resps.size(), exp_rsp.size());
      while (resps.size() > 0 && exp_rsp.size() > 0)
         chk({tag, "_rsp"}, resps.pop_front(), exp_rsp.pop_front());
      sent.delete();
      exp_tx.delete();
      resps.delete();
      exp_rsp.delete();
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int t0;
      bit w;
      logic [7:0] a, d;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'(i) ^ 8'h5A;
         rmem[i]    = 8'(i) ^ 8'h5A;
      end
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 8'h00;
      bus.req_data  = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_transmit", transmit, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_timeout", bus.resp_timeout, 0);
      chk("rst_resp_data", bus.resp_data, 0);
      chk("rst_req_ready", bus.req_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1, 8'h3C, 8'hA5);
      wait_resp(1);
      repeat (12) @(negedge clk);
      chk("wr_timeouts", touts, 0);
      compare("wr");

      rsp_delay = 20;
      issue(0, 8'h3C, 8'h00);
      wait_resp(1);
      @(negedge clk);
      chk("rd_ready_after", bus.req_ready, 1);
      compare("rd");

      issue(1, 8'h10, 8'h55);
      k = 0;
      while (!bus.resp_valid && k < 3000) begin
         @(negedge clk);
         k++;
      end
      issue(0, 8'h10, 8'h00);
      chk("b2b_accepted", bus.req_ready, 0);
      wait_resp(2);
      compare("b2b");

      stray_val = 8'h77;
      stray_req++;
      repeat (5) @(negedge clk);
      chk("stray_idle_ready", bus.req_ready, 1);
      chk("stray_idle_resp", resps.size(), 0);
      issue(1, 8'h20, 8'h33);
      wait_sent(3);
      stray_req++;
      wait_resp(1);
      repeat (12) @(negedge clk);
      issue(0, 8'h20, 8'h00);
      wait_resp(2);
      compare("stray");

      repeat (40) begin
         w = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 15));
         d = 8'($urandom);
         rsp_delay = $urandom_range(1, 40);
         dbl = 1'($urandom_range(0, 1));
         issue(w, a, d);
         wait_resp(1);
         repeat (4) @(negedge clk);
         compare("rnd");
      end
      dbl = 0;

`ifdef UART_MEM_TIMEOUT_EN
      rsp_en = 0;
      issue(0, 8'h44, 8'h00);
      wait_sent(2);
      t0 = cyc;
      k = 0;
      while (!bus.resp_timeout && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("to_pulse", bus.resp_timeout, 1);
      chk("to_resp_data", bus.resp_data, 0);
      chk("to_no_valid", bus.resp_valid, 0);
      chk("to_window", (cyc - t0 >= 95) && (cyc - t0 <= 130), 1);
      rsp_en = 1;
      stray_val = 8'h99;
      stray_req++;
      repeat (10) @(negedge clk);
      chk("to_count", touts, 1);
      chk("to_late_ready", bus.req_ready, 1);
      exp_rsp.delete();
      compare("to");
`else
      rsp_en = 0;
      issue(0, 8'h44, 8'h00);
      repeat (300) @(negedge clk);
      chk("hang_ready", bus.req_ready, 0);
      chk("hang_timeouts", touts, 0);
      rsp_en = 1;
      exp_rsp.delete();
      compare("hang");
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
`endif

      issue(1, 8'h60, 8'h11);
      wait_sent(2);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_transmit", transmit, 0);
      chk("arst_tx_byte", tx_byte, 0);
      chk("arst_resp_valid", bus.resp_valid, 0);
      chk("arst_resp_data", bus.resp_data, 0);
      chk("arst_req_ready", bus.req_ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      void'(exp_tx.pop_back());
      exp_rsp.delete();
      compare("rst");
      rsp_delay = 20;
      issue(0, 8'h3C, 8'h00);
      wait_resp(1);
      compare("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
